// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the buffered UART transmitter.
//   PAR_NONE / PAR_EVEN / PAR_ODD : parity selection encodings
//   uart_state_t                  : transmitter FSM states
//   uart_div()                    : clocks per bit, rounded to nearest
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } uart_state_t;

    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data.
// Ports:
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset (flushes pointers)
//   i_push      write request, ignored while full
//   i_push_data write payload
//   i_pop       read request, ignored while empty
//   o_rd_data   head entry, valid the cycle after an accepted pop
//   o_full      DEPTH entries queued
//   o_empty     nothing queued
//   o_level     number of queued entries
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_rd_data;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_rd_data = r_rd_data;
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        if (w_pop_ok)  r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with compile-time framing.
// Ports:
//   sysclk      clock, all logic on rising edge
//   cpu_reset   synchronous active-high reset
//   wr_valid    push request
//   wr_data     payload, LSB sent first
//   wr_ready    high while the FIFO is not full
//   fifo_level  entries currently queued
//   tx_busy     high while a frame is on the line
//   overflow    sticky: a push was attempted while full
//   uart_tx     serial line, idle high, registered
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sysclk,
    input  logic                          cpu_reset,
    input  logic                          wr_valid,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          tx_busy,
    output logic                          overflow,
    output logic                          uart_tx
);

    localparam int DIV   = uart_div(CLK_HZ, BAUD);
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(DIV - 1);
    localparam logic [2:0]       LAST_DATA   = 3'(DATA_BITS - 1);
    localparam logic [2:0]       LAST_STOP   = 3'(STOP_BITS - 1);

    if (DIV < 2) begin : g_chk_div
        $error("uart_tx_fifo: clock divisor %0d below 2", DIV);
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_chk_data
        $error("uart_tx_fifo: DATA_BITS %0d outside 5..8", DATA_BITS);
    end
    if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_chk_par
        $error("uart_tx_fifo: PARITY %0d not 0, 1 or 2", PARITY);
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
        $error("uart_tx_fifo: STOP_BITS %0d not 1 or 2", STOP_BITS);
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("uart_tx_fifo: FIFO_DEPTH %0d not a power of two >= 2", FIFO_DEPTH);
    end

    uart_state_t             r_state;
    uart_state_t             w_state_next;
    logic [CNT_W-1:0]        r_baud;
    logic [2:0]              r_bit;
    logic [DATA_BITS-1:0]    r_shift;
    logic                    r_par;
    logic                    r_tx;
    logic                    r_busy;
    logic                    r_overflow;
    logic                    w_tx_next;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_baud_done;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [DATA_BITS-1:0]    w_fifo_rd_data;

    // Full flag is equivalent to fifo_level == FIFO_DEPTH on the registered pointers.
    assign wr_ready    = !w_fifo_full;
    assign w_push      = wr_valid && wr_ready;
    assign w_baud_done = (r_baud == '0);
    assign uart_tx     = r_tx;
    assign tx_busy     = r_busy;
    assign overflow    = r_overflow;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (sysclk),
        .i_rst       (cpu_reset),
        .i_push      (w_push),
        .i_push_data (wr_data),
        .i_pop       (w_pop),
        .o_rd_data   (w_fifo_rd_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_level     (fifo_level)
    );

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_tx_next = 1'b0;
                if (w_baud_done) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                w_tx_next = r_shift[0];
                if (w_baud_done && r_bit == LAST_DATA)
                    w_state_next = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
            end
            ST_PAR: begin
                w_tx_next = (PARITY == PAR_ODD) ? ~r_par : r_par;
                if (w_baud_done) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                w_tx_next = 1'b1;
                if (w_baud_done && r_bit == LAST_STOP) begin
                    // Chain straight into the next start bit when more data waits.
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Line and busy are registered from the current state, so both trail the FSM by one cycle.
    always_ff @(posedge sysclk) begin
        if (cpu_reset) begin
            r_state    <= ST_IDLE;
            r_baud     <= BAUD_RELOAD;
            r_bit      <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_tx    <= w_tx_next;
            r_busy  <= (r_state != ST_IDLE);
            if (r_state == ST_IDLE || w_state_next != r_state) begin
                r_baud <= BAUD_RELOAD;
                r_bit  <= '0;
            end else if (w_baud_done) begin
                r_baud <= BAUD_RELOAD;
                r_bit  <= r_bit + 3'd1;
            end else begin
                r_baud <= r_baud - CNT_W'(1);
            end
            if (wr_valid && !wr_ready) r_overflow <= 1'b1;
        end
    end

    // FIFO read data becomes valid the cycle after the pop, so the shifter
    // captures it at the end of the start bit rather than at the pop itself.
    always_ff @(posedge sysclk) begin
        if (w_pop)
            r_par <= 1'b0;
        else if (r_state == ST_DATA && w_baud_done)
            r_par <= r_par ^ r_shift[0];

        if (r_state == ST_START && w_baud_done)
            r_shift <= w_fifo_rd_data;
        else if (r_state == ST_DATA && w_baud_done)
            r_shift <= r_shift >> 1;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with DIV = 4.
// Four instances cover 8N1, 8E1, 8O1 and 7N2 framing.
module tb_uart_tx_fifo;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 250_000;
    localparam int DEPTH  = 16;

    logic       clk = 1'b0;
    logic       rst;

    logic       a_valid, a_ready, a_busy, a_ovf, a_tx;
    logic [7:0] a_data;
    logic [4:0] a_level;
    logic       b_valid, b_ready, b_busy, b_ovf, b_tx;
    logic [7:0] b_data;
    logic [4:0] b_level;
    logic       c_valid, c_ready, c_busy, c_ovf, c_tx;
    logic [7:0] c_data;
    logic [4:0] c_level;
    logic       d_valid, d_ready, d_busy, d_ovf, d_tx;
    logic [6:0] d_data;
    logic [4:0] d_level;

    int checks   = 0;
    int failures = 0;

    logic hist [0:759];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8n1 (
        .sysclk(clk), .cpu_reset(rst), .wr_valid(a_valid), .wr_data(a_data),
        .wr_ready(a_ready), .fifo_level(a_level), .tx_busy(a_busy),
        .overflow(a_ovf), .uart_tx(a_tx));

    uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8e1 (
        .sysclk(clk), .cpu_reset(rst), .wr_valid(b_valid), .wr_data(b_data),
        .wr_ready(b_ready), .fifo_level(b_level), .tx_busy(b_busy),
        .overflow(b_ovf), .uart_tx(b_tx));

    uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8o1 (
        .sysclk(clk), .cpu_reset(rst), .wr_valid(c_valid), .wr_data(c_data),
        .wr_ready(c_ready), .fifo_level(c_level), .tx_busy(c_busy),
        .overflow(c_ovf), .uart_tx(c_tx));

    uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(0),
                   .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_7n2 (
        .sysclk(clk), .cpu_reset(rst), .wr_valid(d_valid), .wr_data(d_data),
        .wr_ready(d_ready), .fifo_level(d_level), .tx_busy(d_busy),
        .overflow(d_ovf), .uart_tx(d_tx));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level after edge n, for a word pushed at edge 0 into an idle block.
    function automatic logic exp_line(int n, logic [7:0] d, int nbits, int par);
        int   t;
        int   slot;
        logic p;
        t = n - 2;
        if (t < 0) return 1'b1;
        slot = t / 4;
        if (slot == 0) return 1'b0;
        if (slot <= nbits) return d[slot-1];
        p = 1'b0;
        for (int i = 0; i < nbits; i++) p = p ^ d[i];
        if (par == 1 && slot == nbits + 1) return p;
        if (par == 2 && slot == nbits + 1) return ~p;
        return 1'b1;
    endfunction

    function automatic logic exp_busy(int n, int nbits, int par, int nstop);
        int total;
        int t;
        total = 1 + nbits + ((par != 0) ? 1 : 0) + nstop;
        t = n - 2;
        return (t >= 0 && t < total * 4);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0; d_valid = 1'b0;
        a_data = '0; b_data = '0; c_data = '0; d_data = '0;
        tick(); tick(); tick();
        checks++;
        if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b1 || a_level !== 5'd0 || a_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_8n1: tx=%b busy=%b ready=%b level=%0d ovf=%b want 1 0 1 0 0",
                     a_tx, a_busy, a_ready, a_level, a_ovf);
        end
        checks++;
        if (b_tx !== 1'b1 || b_busy !== 1'b0 || b_ready !== 1'b1 || b_level !== 5'd0 || b_ovf !== 1'b0 ||
            c_tx !== 1'b1 || c_busy !== 1'b0 || c_ready !== 1'b1 || c_level !== 5'd0 || c_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_parity: b=%b%b%b%0d%b c=%b%b%b%0d%b want 1010 0",
                     b_tx, b_busy, b_ready, b_level, b_ovf, c_tx, c_busy, c_ready, c_level, c_ovf);
        end
        checks++;
        if (d_tx !== 1'b1 || d_busy !== 1'b0 || d_ready !== 1'b1 || d_level !== 5'd0 || d_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_7n2: tx=%b busy=%b ready=%b level=%0d ovf=%b want 1 0 1 0 0",
                     d_tx, d_busy, d_ready, d_level, d_ovf);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_8n1_frame();
        a_valid = 1'b1; a_data = 8'h55;
        tick();                                  // edge 0
        a_valid = 1'b0;
        checks++;
        if (a_level !== 5'd1) begin
            failures++;
            $display("FAIL t1_level_after_push: got %0d want 1", a_level);
        end
        for (int n = 1; n <= 47; n++) begin
            tick();
            if (n == 1) begin
                checks++;
                if (a_level !== 5'd0 || a_tx !== 1'b1) begin
                    failures++;
                    $display("FAIL t1_pop_edge1: level=%0d tx=%b want 0 1", a_level, a_tx);
                end
            end
            checks++;
            if (a_tx !== exp_line(n, 8'h55, 8, 0)) begin
                failures++;
                $display("FAIL t1_line edge %0d: got %b want %b", n, a_tx, exp_line(n, 8'h55, 8, 0));
            end
            checks++;
            if (a_busy !== exp_busy(n, 8, 0, 1)) begin
                failures++;
                $display("FAIL t1_busy edge %0d: got %b want %b", n, a_busy, exp_busy(n, 8, 0, 1));
            end
        end
    endtask

    task automatic test_parity();
        b_valid = 1'b1; b_data = 8'h07;
        c_valid = 1'b1; c_data = 8'h07;
        tick();                                  // edge 0
        b_valid = 1'b0; c_valid = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            tick();
            checks++;
            if (b_tx !== exp_line(n, 8'h07, 8, 1)) begin
                failures++;
                $display("FAIL t2_even_line edge %0d: got %b want %b", n, b_tx, exp_line(n, 8'h07, 8, 1));
            end
            checks++;
            if (c_tx !== exp_line(n, 8'h07, 8, 2)) begin
                failures++;
                $display("FAIL t2_odd_line edge %0d: got %b want %b", n, c_tx, exp_line(n, 8'h07, 8, 2));
            end
            checks++;
            if (b_busy !== exp_busy(n, 8, 1, 1) || c_busy !== exp_busy(n, 8, 2, 1)) begin
                failures++;
                $display("FAIL t2_busy edge %0d: got %b/%b want %b", n, b_busy, c_busy, exp_busy(n, 8, 1, 1));
            end
            if (n == 38) begin
                checks++;
                if (b_tx !== 1'b1 || c_tx !== 1'b0) begin
                    failures++;
                    $display("FAIL t2_parity_bit: even=%b odd=%b want 1 0", b_tx, c_tx);
                end
            end
        end
    endtask

    task automatic test_7n2_frame();
        d_valid = 1'b1; d_data = 7'h41;
        tick();                                  // edge 0
        d_valid = 1'b0;
        for (int n = 1; n <= 46; n++) begin
            tick();
            checks++;
            if (d_tx !== exp_line(n, 8'h41, 7, 0)) begin
                failures++;
                $display("FAIL t6_line edge %0d: got %b want %b", n, d_tx, exp_line(n, 8'h41, 7, 0));
            end
            checks++;
            if (d_busy !== exp_busy(n, 7, 0, 2)) begin
                failures++;
                $display("FAIL t6_busy edge %0d: got %b want %b", n, d_busy, exp_busy(n, 7, 0, 2));
            end
        end
    endtask

    task automatic test_overflow();
        int         starts [0:31];
        int         nfr;
        int         n;
        logic [7:0] got;
        logic [7:0] want;
        a_valid = 1'b1; a_data = 8'hA0;
        tick(); hist[0] = a_tx;                  // edge 0
        a_valid = 1'b0;
        tick(); hist[1] = a_tx;                  // edge 1: popped, line now busy
        for (int i = 0; i <= 16; i++) begin
            if (i == 16) begin
                checks++;
                if (a_ready !== 1'b0 || a_level !== 5'd16) begin
                    failures++;
                    $display("FAIL t3_full_before_17th: ready=%b level=%0d want 0 16", a_ready, a_level);
                end
            end
            a_valid = 1'b1; a_data = 8'(8'h10 + i);
            tick(); hist[2+i] = a_tx;
        end
        a_valid = 1'b0;
        checks++;
        if (a_ovf !== 1'b1 || a_level !== 5'd16) begin
            failures++;
            $display("FAIL t3_overflow_set: ovf=%b level=%0d want 1 16", a_ovf, a_level);
        end
        for (int e = 19; e < 760; e++) begin
            tick(); hist[e] = a_tx;
        end
        nfr = 0;
        n = 1;
        while (n < 760) begin
            if (hist[n] == 1'b0) begin
                if (nfr < 32) starts[nfr] = n;
                nfr++;
                n = n + 40;
            end else begin
                n++;
            end
        end
        checks++;
        if (nfr != 17) begin
            failures++;
            $display("FAIL t3_frame_count: got %0d want 17", nfr);
        end
        checks++;
        if (nfr < 1 || starts[0] != 2) begin
            failures++;
            $display("FAIL t3_first_start: got %0d want 2", (nfr < 1) ? -1 : starts[0]);
        end
        for (int k = 0; k < 17 && k < nfr; k++) begin
            if (k > 0) begin
                checks++;
                if (starts[k] - starts[k-1] != 40) begin
                    failures++;
                    $display("FAIL t3_spacing frame %0d: got %0d want 40", k, starts[k] - starts[k-1]);
                end
            end
            got = '0;
            for (int i = 0; i < 8; i++)
                if (starts[k] + 5 + 4*i < 760) got[i] = hist[starts[k] + 5 + 4*i];
            want = (k == 0) ? 8'hA0 : 8'(8'h10 + k - 1);
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL t3_payload frame %0d: got %h want %h", k, got, want);
            end
        end
        checks++;
        if (a_busy !== 1'b0 || a_level !== 5'd0 || a_ovf !== 1'b1) begin
            failures++;
            $display("FAIL t3_drained: busy=%b level=%0d ovf=%b want 0 0 1", a_busy, a_level, a_ovf);
        end
    endtask

    task automatic test_push_pop_same_cycle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (a_ovf !== 1'b0) begin
            failures++;
            $display("FAIL t4_ovf_cleared: got %b want 0", a_ovf);
        end
        a_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin        // edges 0..5
            a_data = 8'(8'h20 + i);
            tick();
        end
        a_valid = 1'b0;
        checks++;
        if (a_level !== 5'd5) begin
            failures++;
            $display("FAIL t4_level_five: got %0d want 5", a_level);
        end
        for (int e = 6; e <= 40; e++) tick();
        a_valid = 1'b1; a_data = 8'h30;
        tick();                                  // edge 41: push + end-of-frame pop
        a_valid = 1'b0;
        checks++;
        if (a_level !== 5'd5) begin
            failures++;
            $display("FAIL t4_push_pop_level: got %0d want 5", a_level);
        end
        tick();                                  // edge 42
        checks++;
        if (a_tx !== 1'b0 || a_level !== 5'd5) begin
            failures++;
            $display("FAIL t4_second_start: tx=%b level=%0d want 0 5", a_tx, a_level);
        end
        for (int i = 0; i < 11; i++) begin       // edges 43..53
            a_valid = 1'b1; a_data = 8'(8'h40 + i);
            tick();
        end
        a_valid = 1'b0;
        checks++;
        if (a_level !== 5'd16 || a_ready !== 1'b0 || a_ovf !== 1'b0) begin
            failures++;
            $display("FAIL t4_full: level=%0d ready=%b ovf=%b want 16 0 0", a_level, a_ready, a_ovf);
        end
        for (int e = 54; e <= 80; e++) tick();
        checks++;
        if (a_ready !== 1'b0) begin
            failures++;
            $display("FAIL t4_ready_before_pop: got %b want 0", a_ready);
        end
        a_valid = 1'b1; a_data = 8'hEE;
        tick();                                  // edge 81: push while full + pop
        a_valid = 1'b0;
        checks++;
        if (a_level !== 5'd15 || a_ovf !== 1'b1) begin
            failures++;
            $display("FAIL t4_full_push_rejected: level=%0d ovf=%b want 15 1", a_level, a_ovf);
        end
    endtask

    task automatic test_reset_mid_frame();
        int guard;
        int zeros;
        int nonempty;
        guard = 0;
        while (!(a_busy == 1'b0 && a_level == 5'd0) && guard < 1000) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 1000) begin
            failures++;
            $display("FAIL t5_drain_timeout: busy=%b level=%0d after %0d cycles", a_busy, a_level, guard);
        end
        tick(); tick();
        checks++;
        if (a_ovf !== 1'b1) begin
            failures++;
            $display("FAIL t5_ovf_sticky: got %b want 1", a_ovf);
        end
        a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin        // edges 0..3
            a_data = (i == 0) ? 8'hFB : 8'(8'h60 + i);
            tick();
        end
        a_valid = 1'b0;
        checks++;
        if (a_level !== 5'd3) begin
            failures++;
            $display("FAIL t5_queued: got %0d want 3", a_level);
        end
        for (int e = 4; e <= 14; e++) tick();
        checks++;
        if (a_tx !== 1'b0) begin
            failures++;
            $display("FAIL t5_third_bit_low: got %b want 0", a_tx);
        end
        rst = 1'b1;
        tick();                                  // edge 15
        rst = 1'b0;
        checks++;
        if (a_tx !== 1'b1 || a_level !== 5'd0 || a_ovf !== 1'b0 || a_busy !== 1'b0 || a_ready !== 1'b1) begin
            failures++;
            $display("FAIL t5_after_reset: tx=%b level=%0d ovf=%b busy=%b ready=%b want 1 0 0 0 1",
                     a_tx, a_level, a_ovf, a_busy, a_ready);
        end
        zeros = 0;
        nonempty = 0;
        for (int e = 0; e < 100; e++) begin
            tick();
            if (a_tx !== 1'b1) zeros++;
            if (a_level !== 5'd0 || a_busy !== 1'b0) nonempty++;
        end
        checks++;
        if (zeros != 0 || nonempty != 0) begin
            failures++;
            $display("FAIL t5_no_resume: low_samples=%0d active_samples=%0d want 0 0", zeros, nonempty);
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_8n1_frame();
        test_parity();
        test_7n2_frame();
        test_overflow();
        test_push_pop_same_cycle();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter for the `cpu` top level. It replaces a fixed-format serial output with a configurable one: compile-time baud divisor, data width, parity and stop-bit count. A synchronous FIFO decouples CPU store bursts from line rate. Frames leave on `uart_tx` back-to-back while data is queued.

## Interface
- `CLK_HZ`, 100_000_000, sysclk frequency in Hz
- `BAUD`, 115_200, line rate; `DIV = (CLK_HZ + BAUD/2) / BAUD`, must be ≥ 2
- `DATA_BITS`, 8, payload bits per frame, legal 5..8
- `PARITY`, 0, 0 = none, 1 = even, 2 = odd
- `STOP_BITS`, 1, legal 1 or 2
- `FIFO_DEPTH`, 16, entries, power of two ≥ 2
- `sysclk`  in  1  single clock, all logic on rising edge
- `cpu_reset`  in  1  synchronous, active-high reset
- `wr_valid`  in  1  push request
- `wr_data`  in  DATA_BITS  payload, LSB transmitted first
- `wr_ready`  out  1  high when FIFO not full
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  entries currently queued
- `tx_busy`  out  1  high while a frame is on the line
- `overflow`  out  1  sticky: a push was attempted while full
- `uart_tx`  out  1  serial line, idle high

## Operation
- Push accepted on an edge where `wr_valid && wr_ready`. Push while full is dropped and sets `overflow`. `overflow` clears only on reset.
- `wr_ready = (fifo_level != FIFO_DEPTH)`, combinational from the registered count. A push in a full cycle is rejected even if a pop occurs in the same cycle.
- Simultaneous accepted push and pop leaves `fifo_level` unchanged.
- FSM states: IDLE, START, DATA, PAR, STOP. Each bit lasts exactly DIV cycles, timed by a baud counter that restarts on every state entry.
- IDLE: when the FIFO is non-empty, pop, load the shift register, clear the parity accumulator, go to START.
- START drives 0.
- DATA shifts out DATA_BITS bits, LSB first.
- PAR is entered only if PARITY ≠ 0. Even parity: bit = XOR of the data bits. Odd parity: bit = inverted XOR.
- STOP drives 1 for STOP_BITS × DIV cycles.
- Last cycle of STOP: if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Frame length F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × DIV cycles.
- `uart_tx` is a registered output, glitch-free. `tx_busy` is high in every state except IDLE.
- No write bypass: data always passes through the FIFO.

## Timing
- Reset values: `uart_tx`=1, `tx_busy`=0, `wr_ready`=1, `fifo_level`=0, `overflow`=0. FIFO is flushed and the FSM is in IDLE.
- Reset asserted mid-frame: `uart_tx` is 1 from the following edge. Queued data is discarded and no partial frame resumes.
- Latency: push accepted at edge k into an empty, idle block:
  - `fifo_level`=1 after edge k;
  - pop at edge k+1;
  - `uart_tx` falls after edge k+2.
- Back-to-back frames: start-bit falling edges are exactly F cycles apart.
- `tx_busy` falls on the edge that ends the final stop bit when the FIFO is empty.
- Baud counter width is $clog2(DIV); it counts DIV−1 down to 0, and state advances when the count is 0.

## Structure
- Shared package `uart_pkg`: parity encoding constants (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`), FSM state enum, and a `uart_div` function computing DIV.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH): registered read data, pointers with wrap bit, level output, and push/pop/full/empty.
- The top module holds the FSM, baud counter, shift register, parity accumulator, and overflow flag.
- Parameter legality is checked at elaboration (`$error` on illegal values).

## Test plan
Bench parameters: CLK_HZ=1_000_000, BAUD=250_000 (DIV=4), FIFO_DEPTH=16.
1. 8N1, push 0x55 at edge 0 -> `uart_tx` low over edges 2–5, then bits 1,0,1,0,1,0,1,0 (4 cycles each), then high. `tx_busy` falls at edge 42.
2. 8E1, push 0x07 -> parity bit 1, F=44. Rebuild 8O1 with the same data -> parity bit 0.
3. Push 17 words on consecutive cycles while the line is busy -> `wr_ready`=0 at the 17th push, 17th word dropped, `overflow`=1. Exactly 16 frames out, start edges 40 cycles apart.
4. Push and pop in the same cycle at `fifo_level`=5 -> `fifo_level` stays 5. Push at `fifo_level`=16 coinciding with an end-of-frame pop -> rejected, level 15 after.
5. Assert `cpu_reset` during the third data bit with 3 words queued -> `uart_tx`=1 next edge, `fifo_level`=0, `overflow`=0. No further start bits.
6. DATA_BITS=7, STOP_BITS=2, PARITY=none, push 0x41 -> start bit, then 1,0,0,0,0,0,1, then 8 cycles high. F=40, `tx_busy`=0 after.
